pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised successor to the combinational half/full-adder chain in the 8-bit adder project.
- Registered N-bit add/subtract unit; operand width is split into STAGES equal slices, and each slice's carry is registered into the next stage.
- Latency is STAGES cycles, with one new operation per cycle.
- Valid/ready handshake on both sides; sits between operand sources and any consumer needing registered sums.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.
- STAGES, 2, number of pipeline stages; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES must equal 0, otherwise elaboration fails.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_cout  output  1  final carry out; for subtract, 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits clear, so out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - All internal carry and partial-sum registers clear.
  - in_ready returns to 1 on the first edge after release.
- Slicing:
  - SW = WIDTH/STAGES.
  - Stage k (0..STAGES−1) adds bits [k·SW +: SW] of A and of B' with the carry from stage k−1's register.
  - B' = in_sub ? ~in_b : in_b.
  - Carry-in of stage 0 = in_sub.
- Operand skewing: upper slices of A, B' and the already-computed lower sum slices travel with their op through per-stage registers, so each op stays aligned.
- Advance rule:
  - advance = !out_valid | out_ready.
  - When advance=1, all stages shift one position and a bubble (valid=0) is allowed.
  - When advance=0, every stage holds, including data, valid and carry.
  - in_ready = advance (combinational from out_valid and out_ready).
  - Bubbles are not compressed; this is a global-stall pipeline.
- Handshakes:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Latency: an op accepted at edge n appears with out_valid=1 after edge n+STAGES−1 (visible in the cycle following edge n+STAGES−1), assuming no stall. Each stall cycle adds one cycle.
- Throughput: 1 op/cycle with out_ready held high; back-to-back ops are never corrupted.
- Flags, computed in the final stage:
  - out_cout = carry out of the MSB slice.
  - out_ovf = (A[W−1] == B'[W−1]) & (sum[W−1] != A[W−1]).
- Subtract: A−B computed as A + ~B + 1.
  - Equal operands give sum=0, cout=1.
  - in_b=0 with sub gives sum=A, cout=1.
- Simultaneous events:
  - A stall with in_valid=1 must not accept the op (in_ready=0); the source holds it.
  - Accept and emit in the same cycle is legal.
- Reset mid-operation: all in-flight ops are discarded, out_valid drops asynchronously, and no stale result appears after release.
- STAGES=1 degenerates to a single registered adder with latency 1.
- X on in_a/in_b while in_valid=0 must not propagate to out_valid.

Test Plan:
- WIDTH=8, STAGES=2; single op A=0x0F, B=0x01, add, out_ready=1 → after 2 edges out_valid=1 for one cycle, sum=0x10, cout=0, ovf=0.
- Boundary adds, streamed back-to-back:
  - 0xFF+0x01 → sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 → 0x80, cout=0, ovf=1.
  - 0x80+0x80 → 0x00, cout=1, ovf=1.
  - Expect results on 3 consecutive cycles, in order.
- Subtract:
  - 0x05−0x07 → 0xFE, cout=0, ovf=0.
  - 0x80−0x01 → 0x7F, cout=1, ovf=1.
  - 0x33−0x33 → 0x00, cout=1, ovf=0.
- Backpressure: stream 4 ops, drop out_ready for 3 cycles once the first result is valid → in_ready=0 during stall, out_* stable, all 4 results delivered in order, none duplicated or lost.
- Reset mid-op: accept 2 ops, assert rst before the first emerges → out_valid=0 immediately, outputs zero, no result appears after release; a next op of 0x01+0x01 returns 0x02 with normal latency.
- Parameter sweep (WIDTH,STAGES) = (8,1), (8,8), (16,4); random 1000 ops with random out_ready, compared against a behavioural model → zero mismatches; latency equals STAGES when unstalled.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for the pipelined adder.
// Both sides use the same valid/ready rule: a beat moves only in a cycle
// where valid and ready are both high. A source holding valid keeps its
// payload stable until the beat is taken. ready may depend on the
// other side's signals in the same cycle, but valid must not wait for ready.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Operand source and result consumer side
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Adder side
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Registered add/subtract unit split into STAGES equal carry slices.
// Stage k adds slice k of A and B' together with the carry registered by
// stage k-1. The full operands and the partial sum travel down the pipe with
// each op so that every slice sees its own op's bits. The whole pipe advances
// or holds as one unit, which gives a latency of STAGES cycles and one op
// per cycle when the consumer never stalls.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES, with 1 <= STAGES <= WIDTH");
    end

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: operand copies, partial sum, slice carry, valid
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    // Next-state values for each stage
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [SW:0]       sl_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_d;

    logic advance;

    // Global stall: the pipe moves whenever the output slot is empty or being taken
    assign advance = !v_q[LAST] | bus.out_ready;

    // Slice adders: stage 0 works on the incoming op, later stages on the previous register
    always_comb begin
        a_d[0]  = bus.in_a;
        b_d[0]  = bus.in_sub ? ~bus.in_b : bus.in_b;
        s_d[0]  = '0;
        sl_d[0] = {1'b0, a_d[0][SW-1:0]} + {1'b0, b_d[0][SW-1:0]} + {{SW{1'b0}}, bus.in_sub};
        s_d[0][SW-1:0] = sl_d[0][SW-1:0];
        c_d[0]  = sl_d[0][SW];
        v_d[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            s_d[k]  = s_q[k-1];
            sl_d[k] = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
                    + {{SW{1'b0}}, c_q[k-1]};
            s_d[k][k*SW +: SW] = sl_d[k][SW-1:0];
            c_d[k]  = sl_d[k][SW];
            v_d[k]  = v_q[k-1];
        end
    end

    // Pipeline registers: clear on reset, shift together on advance, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.out_sum   = s_q[LAST];
    assign bus.out_cout  = c_q[LAST];
    // Overflow: operands agree in sign but the result does not
    assign bus.out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                         & (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on an 8-bit/2-stage instance and
// randomized streams with random backpressure on four configurations,
// checked against an arithmetic reference model.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared drive, routed to the instance selected by cur_sel
    logic [1:0]  cur_sel;
    logic        cur_in_valid;
    logic        cur_sub;
    logic        cur_out_ready;
    logic [15:0] cur_a;
    logic [15:0] cur_b;

    logic        obs_valid;
    logic        obs_ready;
    logic        obs_cout;
    logic        obs_ovf;
    logic [15:0] obs_sum;

    pipelined_adder_if #(.WIDTH(8))  if_8_2  ();
    pipelined_adder_if #(.WIDTH(8))  if_8_1  ();
    pipelined_adder_if #(.WIDTH(8))  if_8_8  ();
    pipelined_adder_if #(.WIDTH(16)) if_16_4 ();

    pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut_8_2  (.clk(clk), .rst(rst), .bus(if_8_2));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut_8_1  (.clk(clk), .rst(rst), .bus(if_8_1));
    pipelined_adder #(.WIDTH(8),  .STAGES(8)) dut_8_8  (.clk(clk), .rst(rst), .bus(if_8_8));
    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut_16_4 (.clk(clk), .rst(rst), .bus(if_16_4));

    assign if_8_2.in_valid  = (cur_sel == 2'd0) & cur_in_valid;
    assign if_8_2.in_a      = cur_a[7:0];
    assign if_8_2.in_b      = cur_b[7:0];
    assign if_8_2.in_sub    = cur_sub;
    assign if_8_2.out_ready = (cur_sel == 2'd0) ? cur_out_ready : 1'b1;

    assign if_8_1.in_valid  = (cur_sel == 2'd1) & cur_in_valid;
    assign if_8_1.in_a      = cur_a[7:0];
    assign if_8_1.in_b      = cur_b[7:0];
    assign if_8_1.in_sub    = cur_sub;
    assign if_8_1.out_ready = (cur_sel == 2'd1) ? cur_out_ready : 1'b1;

    assign if_8_8.in_valid  = (cur_sel == 2'd2) & cur_in_valid;
    assign if_8_8.in_a      = cur_a[7:0];
    assign if_8_8.in_b      = cur_b[7:0];
    assign if_8_8.in_sub    = cur_sub;
    assign if_8_8.out_ready = (cur_sel == 2'd2) ? cur_out_ready : 1'b1;

    assign if_16_4.in_valid  = (cur_sel == 2'd3) & cur_in_valid;
    assign if_16_4.in_a      = cur_a;
    assign if_16_4.in_b      = cur_b;
    assign if_16_4.in_sub    = cur_sub;
    assign if_16_4.out_ready = (cur_sel == 2'd3) ? cur_out_ready : 1'b1;

    always_comb begin
        obs_valid = if_8_2.out_valid;
        obs_ready = if_8_2.in_ready;
        obs_cout  = if_8_2.out_cout;
        obs_ovf   = if_8_2.out_ovf;
        obs_sum   = {8'h00, if_8_2.out_sum};
        case (cur_sel)
            2'd1: begin
                obs_valid = if_8_1.out_valid;  obs_ready = if_8_1.in_ready;
                obs_cout  = if_8_1.out_cout;   obs_ovf   = if_8_1.out_ovf;
                obs_sum   = {8'h00, if_8_1.out_sum};
            end
            2'd2: begin
                obs_valid = if_8_8.out_valid;  obs_ready = if_8_8.in_ready;
                obs_cout  = if_8_8.out_cout;   obs_ovf   = if_8_8.out_ovf;
                obs_sum   = {8'h00, if_8_8.out_sum};
            end
            2'd3: begin
                obs_valid = if_16_4.out_valid; obs_ready = if_16_4.in_ready;
                obs_cout  = if_16_4.out_cout;  obs_ovf   = if_16_4.out_ovf;
                obs_sum   = if_16_4.out_sum;
            end
            default: ;
        endcase
    end

    // Directed op list and collected results
    logic [15:0] op_a [8];
    logic [15:0] op_b [8];
    logic        op_sub [8];
    logic [15:0] res_sum [8];
    logic        res_cout [8];
    logic        res_ovf [8];
    int          res_cyc [8];
    int          res_n;

    // Driver/monitor: feed n ops back-to-back with out_ready high, record outputs with cycle index
    task automatic run_directed(input int n);
        res_n = 0;
        for (int cyc = 0; cyc < n + 12; cyc++) begin
            @(negedge clk);
            cur_out_ready = 1'b1;
            if (cyc < n) begin
                cur_in_valid = 1'b1;
                cur_a = op_a[cyc];
                cur_b = op_b[cyc];
                cur_sub = op_sub[cyc];
            end else begin
                cur_in_valid = 1'b0;
            end
            #1;
            if (obs_valid && res_n < 8) begin
                res_sum[res_n]  = obs_sum;
                res_cout[res_n] = obs_cout;
                res_ovf[res_n]  = obs_ovf;
                res_cyc[res_n]  = cyc;
                res_n++;
            end
        end
        cur_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        cur_in_valid = 1'b0;
        cur_out_ready = 1'b0;
        rst = 1'b1;
        #12;
        checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", obs_valid); end
        checks++; if (obs_sum !== 16'h0) begin failures++; $display("FAIL reset_sum: got %h expected 0", obs_sum); end
        checks++; if (obs_cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", obs_cout); end
        checks++; if (obs_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", obs_ovf); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", obs_ready); end
        cur_out_ready = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        cur_out_ready = 1'b1;
        cur_in_valid = 1'b1; cur_a = 16'h0F; cur_b = 16'h01; cur_sub = 1'b0;
        @(negedge clk);
        cur_in_valid = 1'b0;
        #1;
        checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL single_early: got valid %b expected 0", obs_valid); end
        @(negedge clk);
        #1;
        checks++;
        if ({obs_valid, obs_sum, obs_cout, obs_ovf} !== {1'b1, 16'h0010, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_result: got v=%b sum=%h c=%b o=%b expected v=1 sum=0010 c=0 o=0",
                     obs_valid, obs_sum, obs_cout, obs_ovf);
        end
        @(negedge clk);
        #1;
        checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle: got valid %b expected 0", obs_valid); end
    endtask

    task automatic test_boundary_add();
        logic [15:0] es [3];
        logic        ec [3];
        logic        eo [3];
        op_a[0] = 16'hFF; op_b[0] = 16'h01; op_sub[0] = 1'b0; es[0] = 16'h00; ec[0] = 1'b1; eo[0] = 1'b0;
        op_a[1] = 16'h7F; op_b[1] = 16'h01; op_sub[1] = 1'b0; es[1] = 16'h80; ec[1] = 1'b0; eo[1] = 1'b1;
        op_a[2] = 16'h80; op_b[2] = 16'h80; op_sub[2] = 1'b0; es[2] = 16'h00; ec[2] = 1'b1; eo[2] = 1'b1;
        run_directed(3);
        checks++; if (res_n !== 3) begin failures++; $display("FAIL boundary_count: got %0d expected 3", res_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_cout[i], res_ovf[i]} !== {es[i], ec[i], eo[i]}) begin
                failures++;
                $display("FAIL boundary_result[%0d]: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                         i, res_sum[i], res_cout[i], res_ovf[i], es[i], ec[i], eo[i]);
            end
            checks++;
            if (res_cyc[i] != 2 + i) begin
                failures++; $display("FAIL boundary_cycle[%0d]: got %0d expected %0d", i, res_cyc[i], 2 + i);
            end
        end
    endtask

    task automatic test_subtract();
        logic [15:0] es [3];
        logic        ec [3];
        logic        eo [3];
        op_a[0] = 16'h05; op_b[0] = 16'h07; op_sub[0] = 1'b1; es[0] = 16'hFE; ec[0] = 1'b0; eo[0] = 1'b0;
        op_a[1] = 16'h80; op_b[1] = 16'h01; op_sub[1] = 1'b1; es[1] = 16'h7F; ec[1] = 1'b1; eo[1] = 1'b1;
        op_a[2] = 16'h33; op_b[2] = 16'h33; op_sub[2] = 1'b1; es[2] = 16'h00; ec[2] = 1'b1; eo[2] = 1'b0;
        run_directed(3);
        checks++; if (res_n !== 3) begin failures++; $display("FAIL sub_count: got %0d expected 3", res_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_sum[i], res_cout[i], res_ovf[i]} !== {es[i], ec[i], eo[i]}) begin
                failures++;
                $display("FAIL sub_result[%0d]: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                         i, res_sum[i], res_cout[i], res_ovf[i], es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] es [4];
        logic        ec [4];
        logic        eo [4];
        logic [15:0] h_sum;
        logic        h_c, h_o;
        int  idx = 0;
        int  stall = 0;
        bit  first = 0;
        bit  holding = 0;
        op_a[0] = 16'h10; op_b[0] = 16'h20; op_sub[0] = 1'b0; es[0] = 16'h30; ec[0] = 1'b0; eo[0] = 1'b0;
        op_a[1] = 16'h01; op_b[1] = 16'h02; op_sub[1] = 1'b0; es[1] = 16'h03; ec[1] = 1'b0; eo[1] = 1'b0;
        op_a[2] = 16'hF0; op_b[2] = 16'h20; op_sub[2] = 1'b0; es[2] = 16'h10; ec[2] = 1'b1; eo[2] = 1'b0;
        op_a[3] = 16'h40; op_b[3] = 16'h40; op_sub[3] = 1'b0; es[3] = 16'h80; ec[3] = 1'b0; eo[3] = 1'b1;
        h_sum = '0; h_c = 1'b0; h_o = 1'b0;
        res_n = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (obs_valid) first = 1;
            if (first && stall < 3) begin
                cur_out_ready = 1'b0;
                stall++;
            end else begin
                cur_out_ready = 1'b1;
            end
            if (idx < 4) begin
                cur_in_valid = 1'b1; cur_a = op_a[idx]; cur_b = op_b[idx]; cur_sub = op_sub[idx];
            end else begin
                cur_in_valid = 1'b0;
            end
            #1;
            if (!cur_out_ready) begin
                checks++;
                if (obs_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", obs_ready); end
                if (holding) begin
                    checks++;
                    if ({obs_valid, obs_sum, obs_cout, obs_ovf} !== {1'b1, h_sum, h_c, h_o}) begin
                        failures++;
                        $display("FAIL bp_hold: got v=%b sum=%h c=%b o=%b expected v=1 sum=%h c=%b o=%b",
                                 obs_valid, obs_sum, obs_cout, obs_ovf, h_sum, h_c, h_o);
                    end
                end
                h_sum = obs_sum; h_c = obs_cout; h_o = obs_ovf;
                holding = 1;
            end else begin
                holding = 0;
            end
            if (obs_valid && cur_out_ready && res_n < 8) begin
                res_sum[res_n] = obs_sum; res_cout[res_n] = obs_cout; res_ovf[res_n] = obs_ovf;
                res_n++;
            end
            if (cur_in_valid && obs_ready) idx++;
        end
        cur_in_valid = 1'b0;
        cur_out_ready = 1'b1;
        checks++; if (res_n !== 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", res_n); end
        for (int i = 0; i < 4 && i < res_n; i++) begin
            checks++;
            if ({res_sum[i], res_cout[i], res_ovf[i]} !== {es[i], ec[i], eo[i]}) begin
                failures++;
                $display("FAIL bp_result[%0d]: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                         i, res_sum[i], res_cout[i], res_ovf[i], es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        @(negedge clk);
        cur_out_ready = 1'b1;
        cur_in_valid = 1'b1; cur_a = 16'h11; cur_b = 16'h22; cur_sub = 1'b0;
        @(negedge clk);
        cur_a = 16'h33; cur_b = 16'h44;
        @(posedge clk);
        #2;
        checks++; if (obs_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b expected 1", obs_valid); end
        rst = 1'b1;
        cur_in_valid = 1'b0;
        #1;
        checks++;
        if ({obs_valid, obs_sum, obs_cout, obs_ovf} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_outputs: got v=%b sum=%h c=%b o=%b expected all zero",
                     obs_valid, obs_sum, obs_cout, obs_ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (obs_valid) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale: got %0d results expected 0", stale); end
        op_a[0] = 16'h01; op_b[0] = 16'h01; op_sub[0] = 1'b0;
        run_directed(1);
        checks++;
        if (res_n != 1 || res_sum[0] !== 16'h02 || res_cyc[0] != 2) begin
            failures++;
            $display("FAIL mid_next_op: got n=%0d sum=%h cyc=%0d expected n=1 sum=0002 cyc=2",
                     res_n, res_sum[0], res_cyc[0]);
        end
    endtask

    // Random stream with random out_ready, checked against arithmetic model and latency
    task automatic test_random(input logic [1:0] sel, input int w, input int s, input int nops);
        logic [17:0] exp_q [$];
        int          stamp_q [$];
        logic [17:0] e, held;
        int unsigned mask, av, bv, full, sum;
        int          half, sa, sb, r, st;
        logic        cout, ovf, advance;
        int  adv = 0, sent = 0, cyc = 0;
        bit  offer = 0, hold_pending = 0;
        mask = (32'd1 << w) - 1;
        half = 1 << (w - 1);
        held = '0;
        cur_sel = sel;
        cur_in_valid = 1'b0;
        while ((sent < nops || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            cur_out_ready = (sent >= nops) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!offer && sent < nops && $urandom_range(0, 9) < 7) begin
                offer = 1;
                cur_a = 16'($urandom & mask);
                cur_b = 16'($urandom & mask);
                cur_sub = 1'($urandom_range(0, 1));
            end
            cur_in_valid = offer;
            if (!offer) begin
                cur_a = 16'($urandom);
                cur_b = 16'($urandom);
            end
            #1;
            advance = !obs_valid || cur_out_ready;
            checks++;
            if (obs_ready !== advance) begin
                failures++; $display("FAIL rand%0d_in_ready: got %b expected %b", sel, obs_ready, advance);
            end
            if (hold_pending) begin
                checks++;
                if ({obs_cout, obs_ovf, obs_sum} !== held || obs_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rand%0d_hold: got v=%b %h expected v=1 %h", sel, obs_valid,
                             {obs_cout, obs_ovf, obs_sum}, held);
                end
            end
            hold_pending = obs_valid && !cur_out_ready;
            held = {obs_cout, obs_ovf, obs_sum};
            if (obs_valid && cur_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand%0d_spurious: got sum=%h expected no result", sel, obs_sum);
                end else begin
                    e = exp_q.pop_front();
                    st = stamp_q.pop_front();
                    if ({obs_cout, obs_ovf, obs_sum} !== e) begin
                        failures++;
                        $display("FAIL rand%0d_result: got c/o/sum=%h expected %h", sel,
                                 {obs_cout, obs_ovf, obs_sum}, e);
                    end
                    checks++;
                    if (adv - st != s - 1) begin
                        failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", sel, adv - st + 1, s);
                    end
                end
            end
            if (offer && obs_ready) begin
                av = 32'(cur_a) & mask;
                bv = 32'(cur_b) & mask;
                sa = (av >= 32'(half)) ? int'(av) - 2 * half : int'(av);
                sb = (bv >= 32'(half)) ? int'(bv) - 2 * half : int'(bv);
                if (cur_sub) begin
                    sum  = (av - bv) & mask;
                    cout = (av >= bv);
                    r    = sa - sb;
                end else begin
                    full = av + bv;
                    sum  = full & mask;
                    cout = ((full >> w) & 1) != 0;
                    r    = sa + sb;
                end
                ovf = (r > half - 1) || (r < -half);
                exp_q.push_back({cout, ovf, sum[15:0]});
                stamp_q.push_back(adv + 1);
                sent++;
                offer = 0;
            end
            if (advance) adv++;
        end
        cur_in_valid = 1'b0;
        cur_out_ready = 1'b1;
        checks++;
        if (cyc >= 20000) begin
            failures++; $display("FAIL rand%0d_timeout: got sent=%0d pending=%0d expected all drained", sel, sent, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cur_sel = 2'd0;
        cur_in_valid = 1'b0;
        cur_out_ready = 1'b1;
        cur_a = '0;
        cur_b = '0;
        cur_sub = 1'b0;
        test_reset();
        test_single_add();
        test_boundary_add();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_random(2'd0, 8, 2, 1000);
        test_random(2'd1, 8, 1, 1000);
        test_random(2'd2, 8, 8, 1000);
        test_random(2'd3, 16, 4, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
